// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU handshake and display signals of calc_sequencer
//   keypad : ready (strobe), tecla[3:0] (key code)
//   alu    : alu_req/alu_op/alu_a/alu_b out, alu_ack/alu_result/alu_carry back
//   status : display[7:0], error, estate[2:0]
//   master : drives keypad and ALU response (environment side)
//   slave  : the sequencer itself
interface calc_sequencer_if;
  logic       ready;
  logic [3:0] tecla;
  logic       alu_ack;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_req;
  logic       alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] display;
  logic       error;
  logic [2:0] estate;
  modport master (
    output ready, tecla, alu_ack, alu_result, alu_carry,
    input  alu_req, alu_op, alu_a, alu_b, display, error, estate
  );
  modport slave (
    input  ready, tecla, alu_ack, alu_result, alu_carry,
    output alu_req, alu_op, alu_a, alu_b, display, error, estate
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven two-operand calculator sequencer around an external ALU
//   Clock   : rising-edge clock
//   clearIn : synchronous active-high reset
//   bus     : calc_sequencer_if.slave (keypad in, ALU handshake, display/error/estate out)
//   ALU_TIMEOUT : max WAIT_ALU cycles before alu_ack, else ERROR
//   DIGIT_SAT_EN: when defined, digit overflow clamps to 255 instead of going to ERROR
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 15
) (
  input logic             Clock,
  input logic             clearIn,
  calc_sequencer_if.slave bus
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [3:0] K_CE = 4'hA, K_SUB = 4'hB, K_ADD = 4'hC, K_IGUAL = 4'hD, K_SAVE = 4'hE, K_REC = 4'hF;
  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    RESULT   = 3'd3,
    ERROR    = 3'd4
  } state_t;
  state_t          state_q, state_d;
  logic [7:0]      a_q, a_d, b_q, b_d, mem_q, mem_d, res_q, res_d, disp_q, disp_d;
  logic            op_q, op_d, req_q, req_d, err_q, err_d, ready_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            key, is_dig, is_op;
  logic [7:0]      opnd, dig_val;
  logic [11:0]     acc;
  logic            ovf, dig_err;
  assign key    = bus.ready & ~ready_q;
  assign is_dig = bus.tecla <= 4'd9;
  assign is_op  = bus.tecla == K_ADD || bus.tecla == K_SUB;
  // Only one operand accumulates digits at a time, so a single multiplier serves both.
  assign opnd   = state_q == ENTER_B ? b_q : a_q;
  assign acc    = {4'b0, opnd} * 12'd10 + {8'b0, bus.tecla};
  assign ovf    = |acc[11:8];
`ifdef DIGIT_SAT_EN
  assign dig_val = ovf ? 8'hFF : acc[7:0];
  assign dig_err = 1'b0;
`else
  assign dig_val = ovf ? opnd : acc[7:0];
  assign dig_err = ovf;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mem_d   = mem_q;
    res_d   = res_q;
    op_d    = op_q;
    req_d   = 1'b0;
    cnt_d   = '0;
    case (state_q)
      ENTER_A: if (key) begin
        if (is_dig) begin
          a_d     = dig_val;
          state_d = dig_err ? ERROR : ENTER_A;
        end else if (is_op) begin
          op_d    = bus.tecla == K_SUB;
          b_d     = '0;
          state_d = ENTER_B;
        end else if (bus.tecla == K_SAVE) mem_d = a_q;
        else if (bus.tecla == K_REC) a_d = mem_q;
        else if (bus.tecla == K_CE) a_d = '0;
      end
      ENTER_B: if (key) begin
        if (is_dig) begin
          b_d     = dig_val;
          state_d = dig_err ? ERROR : ENTER_B;
        end else if (is_op) op_d = bus.tecla == K_SUB;
        else if (bus.tecla == K_IGUAL) state_d = WAIT_ALU;
        else if (bus.tecla == K_SAVE) mem_d = b_q;
        else if (bus.tecla == K_REC) b_d = mem_q;
        else b_d = '0;
      end
      // req rises one cycle after entry because it is only set while already waiting.
      WAIT_ALU: if (bus.alu_ack) begin
        res_d   = bus.alu_result;
        state_d = bus.alu_carry ? ERROR : RESULT;
      end else if (cnt_q == CW'(ALU_TIMEOUT - 1)) state_d = ERROR;
      else begin
        cnt_d = cnt_q + 1'b1;
        req_d = 1'b1;
      end
      RESULT: if (key) begin
        if (is_dig) begin
          a_d     = {4'b0, bus.tecla};
          b_d     = '0;
          state_d = ENTER_A;
        end else if (is_op) begin
          a_d     = res_q;
          op_d    = bus.tecla == K_SUB;
          b_d     = '0;
          state_d = ENTER_B;
        end else if (bus.tecla == K_IGUAL) begin
          a_d     = res_q;
          state_d = WAIT_ALU;
        end else if (bus.tecla == K_SAVE) mem_d = res_q;
        else if (bus.tecla == K_REC) begin
          a_d     = mem_q;
          state_d = ENTER_A;
        end else begin
          a_d     = '0;
          state_d = ENTER_A;
        end
      end
      ERROR: if (key && bus.tecla == K_CE) begin
        a_d     = '0;
        b_d     = '0;
        state_d = ENTER_A;
      end
      default: state_d = ENTER_A;
    endcase
    disp_d = state_d == ENTER_A ? a_d :
             (state_d == ENTER_B || state_d == WAIT_ALU) ? b_d :
             state_d == RESULT ? res_d : 8'd0;
    err_d  = state_d == ERROR;
  end
  always_ff @(posedge Clock) begin
    if (clearIn) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      mem_q   <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      op_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mem_q   <= mem_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      op_q    <= op_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ready_q <= bus.ready;
    end
  end
  assign bus.alu_req = req_q;
  assign bus.alu_op  = op_q;
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.display = disp_q;
  assign bus.error   = err_q;
  assign bus.estate  = state_q;
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter ALU_TIMEOUT, default 15, meaning the maximum number of WAIT_ALU cycles allowed before alu_ack.
REQ-002 SHALL have port Clock, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port clearIn, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ready, input, 1, keypad strobe; a key event is a 0->1 transition of ready.
REQ-005 SHALL have port tecla, input, 4, key code: 0-9 digit, 1010 CE, 1011 SUB, 1100 ADD, 1101 IGUAL, 1110 SAVE, 1111 RECOVERY.
REQ-006 SHALL have port alu_ack, input, 1, the ALU result is valid this cycle.
REQ-007 SHALL have port alu_result, input, 8, the ALU result.
REQ-008 SHALL have port alu_carry, input, 1, ADD overflow or SUB borrow, valid with alu_ack.
REQ-009 SHALL have port alu_req, output, 1, the ALU operation request.
REQ-010 SHALL have port alu_op, output, 1, 0 means ADD and 1 means SUB.
REQ-011 SHALL have port alu_a, output, 8, operand A.
REQ-012 SHALL have port alu_b, output, 8, operand B.
REQ-013 SHALL have port display, output, 8, the value shown.
REQ-014 SHALL have port error, output, 1, high while in ERROR.
REQ-015 SHALL have port estate, output, 3, the current state encoding.

Function
REQ-016 SHALL detect key events via a registered copy of ready.
- Exactly one action per 0->1 transition.
- Held ready SHALL NOT repeat the action.
REQ-017 SHALL apply each key action at the clock edge that samples the event; results are visible the next cycle.
REQ-018 SHALL implement these states and encodings: ENTER_A=0, ENTER_B=1, WAIT_ALU=2, RESULT=3, ERROR=4.
REQ-019 Digit entry SHALL compute operand = operand*10 + digit, evaluated at 12 bits; a value >255 is an overflow.
REQ-020 In ENTER_A, the following keys SHALL behave as listed:
- digit: accumulates into A.
- ADD/SUB: latches alu_op, sets B=0, goes to ENTER_B.
- SAVE: mem=A.
- RECOVERY: A=mem.
- CE: A=0.
- IGUAL and unused codes: ignored.
REQ-021 In ENTER_B, the following keys SHALL behave as listed:
- digit: accumulates into B.
- ADD/SUB: replaces alu_op; B unchanged.
- IGUAL: goes to WAIT_ALU.
- SAVE: mem=B.
- RECOVERY: B=mem.
- CE: B=0.
REQ-022 In WAIT_ALU, alu_req SHALL be high starting the cycle after entry, with alu_a, alu_b and alu_op held stable until alu_ack is sampled high; key events SHALL be discarded.
REQ-023 On alu_ack in WAIT_ALU:
- latch alu_result into result, drop alu_req next cycle.
- go to RESULT if alu_carry=0, else go to ERROR.
REQ-024 A cycle counter SHALL run in WAIT_ALU; reaching ALU_TIMEOUT without alu_ack SHALL go to ERROR with alu_req deasserted.
REQ-025 In RESULT, the following keys SHALL behave as listed:
- digit d: A=d, B=0, goes to ENTER_A.
- ADD/SUB: A=result, latches op, B=0, goes to ENTER_B (chaining).
- IGUAL: A=result, B kept, goes to WAIT_ALU (repeat).
- SAVE: mem=result.
- RECOVERY: A=mem, goes to ENTER_A.
- CE: A=0, goes to ENTER_A.
REQ-026 In ERROR, only CE SHALL exit, to ENTER_A with A=B=0 and mem preserved; all other keys are ignored.
REQ-027 display SHALL be registered and show the following per state:
- ENTER_A: A.
- ENTER_B: B.
- WAIT_ALU: B.
- RESULT: result.
- ERROR: 0.
REQ-028 alu_ack outside WAIT_ALU SHALL be ignored.

Reset
REQ-029 While clearIn=1, the following SHALL hold:
- estate=ENTER_A.
- A=B=mem=result=0, alu_op=0.
- alu_req=0, error=0, display=0.
- timeout counter and ready register cleared.
REQ-030 clearIn SHALL take priority over key events and alu_ack in the same cycle, including mid-WAIT_ALU.

Configuration
REQ-031 Macro DIGIT_SAT_EN SHALL select the digit-entry overflow behaviour:
- defined: an overflowing digit entry clamps the operand to 255 and the state is unchanged.
- undefined: an overflowing digit entry goes to ERROR and the operand is unchanged.

Verification
REQ-032 Keys 1,2,ADD,3,IGUAL, then alu_ack with result 15 and carry 0 two cycles after alu_req -> alu_a=12, alu_b=3, alu_op=0, display=15, estate=3.
REQ-033 Keys 2,5,6 -> without DIGIT_SAT_EN: error=1, estate=4, display=0; with DIGIT_SAT_EN: display=255, estate=0.
REQ-034 Keys 7,SUB,9,IGUAL, then alu_ack with carry 1 -> estate=4, error=1; then CE -> estate=0, display=0.
REQ-035 Keys 1,ADD,1,IGUAL with alu_ack held 0 -> estate=4 after ALU_TIMEOUT cycles, alu_req=0.
REQ-036 Result 15, then keys SAVE,4,ADD,RECOVERY,IGUAL -> alu_a=4, alu_b=15; ready held high for 10 cycles -> only one action.
REQ-037 clearIn=1 in the same cycle as alu_ack in WAIT_ALU -> estate=0, all registers 0, ack ignored.
